// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog timer: state encoding, tick
// base encodings and default counter width.
package wdt_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WARN    = 2'd2,
    ST_EXPIRED = 2'd3
  } wdt_state_e;

  localparam logic [1:0] TSEL_USEC = 2'd0;
  localparam logic [1:0] TSEL_MSEC = 2'd1;
  localparam logic [1:0] TSEL_SEC  = 2'd2;
  localparam logic [1:0] TSEL_NONE = 2'd3;

endpackage

// File: rtl/watchdog_timer_if.sv
// Control/status bundle of the watchdog timer; WDT_WINDOW_EN adds the
// kick-window configuration and the early-kick flag.
interface watchdog_timer_if #(parameter int CNT_W = wdt_pkg::CNT_W_DEFAULT);

  logic             usec_pulse;
  logic             msec_pulse;
  logic             sec_pulse;
  logic [1:0]       tick_sel;
  logic             enable;
  logic [CNT_W-1:0] timeout;
  logic [CNT_W-1:0] warn_thresh;
  logic             kick;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             warn_pulse;
  logic             expired;
`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] window_min;
  logic             early_kick;

  modport master (
    output usec_pulse, msec_pulse, sec_pulse, tick_sel, enable, timeout,
           warn_thresh, kick, window_min,
    input  count, state, warn_pulse, expired, early_kick
  );

  modport slave (
    input  usec_pulse, msec_pulse, sec_pulse, tick_sel, enable, timeout,
           warn_thresh, kick, window_min,
    output count, state, warn_pulse, expired, early_kick
  );
`else
  modport master (
    output usec_pulse, msec_pulse, sec_pulse, tick_sel, enable, timeout,
           warn_thresh, kick,
    input  count, state, warn_pulse, expired
  );

  modport slave (
    input  usec_pulse, msec_pulse, sec_pulse, tick_sel, enable, timeout,
           warn_thresh, kick,
    output count, state, warn_pulse, expired
  );
`endif

endinterface

// File: rtl/wdt_tick_sel.sv
// Picks the upstream pulse matching the latched time base and registers it
// as a single tick strobe; clr drops an in-flight tick when the counter reloads.
module wdt_tick_sel
  import wdt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usec_pulse,
  input  logic       msec_pulse,
  input  logic       sec_pulse,
  input  logic [1:0] sel,
  input  logic       clr,
  output logic       tick
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    case (sel)
      TSEL_USEC: hit = usec_pulse;
      TSEL_MSEC: hit = msec_pulse;
      TSEL_SEC:  hit = sec_pulse;
      default:   hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else if (clr) begin
      tick <= 1'b0;
    end else begin
      tick <= hit;
    end
  end

endmodule

// File: rtl/watchdog_timer.sv
// Watchdog timer: counts selected ticks down from a latched timeout, warns at
// a threshold and expires at zero. WDT_WINDOW_EN adds a minimum kick window.
module watchdog_timer
  import wdt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
)
(
  input  logic             clk,
  input  logic             rst_n,
  watchdog_timer_if.slave  bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  wdt_state_e state_q, state_d;
  cnt_t       count_q, count_d;
  cnt_t       timeout_q, timeout_d;
  cnt_t       thresh_q, thresh_d;
  logic [1:0] tsel_q, tsel_d;
  logic       warn_q, warn_d;
  logic       load;
  logic       tick;
  cnt_t       dec;

  assign dec = count_q - cnt_t'(1);

`ifdef WDT_WINDOW_EN
  cnt_t winmin_q, winmin_d;
  logic early_q, early_d;
  logic early_hit;

  // Elapsed ticks since the last load must reach window_min before a kick is legal.
  assign early_hit = (timeout_q - count_q) < winmin_q;
`endif

  wdt_tick_sel u_tick_sel (
    .clk        (clk),
    .rst_n      (rst_n),
    .usec_pulse (bus.usec_pulse),
    .msec_pulse (bus.msec_pulse),
    .sec_pulse  (bus.sec_pulse),
    .sel        (tsel_q),
    .clr        (load),
    .tick       (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      timeout_q <= '0;
      thresh_q  <= '0;
      tsel_q    <= '0;
      warn_q    <= 1'b0;
`ifdef WDT_WINDOW_EN
      winmin_q  <= '0;
      early_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      thresh_q  <= thresh_d;
      tsel_q    <= tsel_d;
      warn_q    <= warn_d;
`ifdef WDT_WINDOW_EN
      winmin_q  <= winmin_d;
      early_q   <= early_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    thresh_d  = thresh_q;
    tsel_d    = tsel_q;
    warn_d    = 1'b0;
    load      = 1'b0;
`ifdef WDT_WINDOW_EN
    winmin_d  = winmin_q;
    early_d   = early_q;
`endif

    if (!bus.enable) begin
      state_d = ST_IDLE;
      count_d = '0;
`ifdef WDT_WINDOW_EN
      early_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: load = 1'b1;
        ST_RUN, ST_WARN: begin
          if (bus.kick) begin
`ifdef WDT_WINDOW_EN
            if (early_hit) begin
              state_d = ST_EXPIRED;
              count_d = '0;
              early_d = 1'b1;
            end else begin
              load = 1'b1;
            end
`else
            load = 1'b1;
`endif
          end else if (tick) begin
            count_d = dec;
            if (dec == '0) begin
              state_d = ST_EXPIRED;
            end else if (state_q == ST_RUN && thresh_q != '0 && dec == thresh_q) begin
              state_d = ST_WARN;
              warn_d  = 1'b1;
            end
          end
        end
        default: count_d = '0;
      endcase
    end

    if (load) begin
      timeout_d = bus.timeout;
      thresh_d  = bus.warn_thresh;
      tsel_d    = bus.tick_sel;
`ifdef WDT_WINDOW_EN
      winmin_d  = bus.window_min;
`endif
      count_d   = bus.timeout;
      // A zero timeout from IDLE expires straight away; a kick always restarts RUN.
      state_d   = (state_q == ST_IDLE && bus.timeout == '0) ? ST_EXPIRED : ST_RUN;
    end
  end

  assign bus.count      = count_q;
  assign bus.state      = state_q;
  assign bus.warn_pulse = warn_q;
  assign bus.expired    = (state_q == ST_EXPIRED);
`ifdef WDT_WINDOW_EN
  assign bus.early_kick = early_q;
`endif

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed and randomized bench for watchdog_timer against a cycle-level
// reference model derived from the watchdog rules.
module tb_watchdog_timer;

  localparam int CW   = 16;
  localparam int MASK = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  watchdog_timer_if #(.CNT_W(CW)) bus ();

  watchdog_timer #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: state 0..3, remaining ticks, config captured at load,
  // and whether a selected upstream pulse was seen last cycle.
  int m_state, m_count, m_to, m_wt, m_ts, m_wm;
  bit m_warn, m_early, m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_to = 0; m_wt = 0; m_ts = 0; m_wm = 0;
    m_warn = 0; m_early = 0; m_pend = 0;
  endtask

  task automatic model_step();
    bit hit, reload;
    int wm_in;
    hit = (m_ts == 0 && bus.usec_pulse) || (m_ts == 1 && bus.msec_pulse) ||
          (m_ts == 2 && bus.sec_pulse);
    reload = 0;
    m_warn = 0;
`ifdef WDT_WINDOW_EN
    wm_in = int'(bus.window_min);
`else
    wm_in = 0;
`endif
    if (!bus.enable) begin
      m_state = 0; m_count = 0; m_early = 0;
    end else if (m_state == 0) begin
      reload = 1;
    end else if (m_state == 3) begin
      m_count = 0;
    end else if (bus.kick) begin
`ifdef WDT_WINDOW_EN
      if (m_to - m_count < m_wm) begin
        m_state = 3; m_count = 0; m_early = 1;
      end else reload = 1;
`else
      reload = 1;
`endif
    end else if (m_pend) begin
      m_count = (m_count - 1) & MASK;
      if (m_count == 0) m_state = 3;
      else if (m_state == 1 && m_wt != 0 && m_count == m_wt) begin
        m_state = 2; m_warn = 1;
      end
    end
    if (reload) begin
      m_to = int'(bus.timeout); m_wt = int'(bus.warn_thresh);
      m_ts = int'(bus.tick_sel); m_wm = wm_in;
      m_count = m_to;
      m_state = (m_state == 0 && m_to == 0) ? 3 : 1;
    end
    m_pend = reload ? 1'b0 : hit;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'(m_count));
    check({tag, ".state"}, 32'(bus.state), 32'(m_state));
    check({tag, ".warn_pulse"}, 32'(bus.warn_pulse), 32'(m_warn));
    check({tag, ".expired"}, 32'(bus.expired), 32'(m_state == 3));
`ifdef WDT_WINDOW_EN
    check({tag, ".early_kick"}, 32'(bus.early_kick), 32'(m_early));
`endif
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // One clock with the given pulses/kick held, then released.
  task automatic cyc(input string tag, input bit u, input bit m, input bit s, input bit k);
    bus.usec_pulse = u; bus.msec_pulse = m; bus.sec_pulse = s; bus.kick = k;
    step(tag);
    bus.usec_pulse = 0; bus.msec_pulse = 0; bus.sec_pulse = 0; bus.kick = 0;
  endtask

  task automatic cfg(input int to, input int wt, input int ts, input int wm);
    bus.timeout = 16'(to); bus.warn_thresh = 16'(wt); bus.tick_sel = 2'(ts);
`ifdef WDT_WINDOW_EN
    bus.window_min = 16'(wm);
`else
    if (wm != 0) $display("window_min %0d ignored in this build", wm);
`endif
  endtask

  initial begin
    bus.usec_pulse = 0; bus.msec_pulse = 0; bus.sec_pulse = 0; bus.kick = 0;
    bus.enable = 0;
    cfg(0, 0, 0, 0);
    model_reset();

    #12;
    check("rst.count", 32'(bus.count), 0);
    check("rst.state", 32'(bus.state), 0);
    check("rst.warn", 32'(bus.warn_pulse), 0);
    check("rst.expired", 32'(bus.expired), 0);
    @(posedge clk); #1;
    rst_n = 1;
    step("idle_hold");

    // Warning after the 3rd msec pulse, expiry after the 5th.
    cfg(5, 2, 1, 0);
    bus.enable = 1;
    step("load5");
    for (int i = 1; i <= 5; i++) begin
      cyc("ms_pulse", 0, 1, 0, 0);
      cyc("ms_gap", 0, 0, 0, 0);
      if (i == 3) check("warn_after_3rd", 32'(bus.state), 2);
    end
    check("exp5.expired", 32'(bus.expired), 1);
    check("exp5.count", 32'(bus.count), 0);
    cyc("exp_ignore_kick", 0, 1, 0, 1);
    bus.enable = 0;
    step("drop_enable");

    // Kick coincident with a tick reloads without decrementing.
    cfg(4, 0, 1, 0);
    bus.enable = 1;
    step("load4");
    cyc("t1", 0, 1, 0, 0);
    cyc("t1_gap", 0, 0, 0, 0);
    cyc("t2_kick", 0, 1, 0, 1);
    cyc("t2_gap", 0, 0, 0, 0);
    check("kick_tick.count", 32'(bus.count), 4);
    check("kick_tick.state", 32'(bus.state), 1);

    // Enable drop while in WARN wins over a simultaneous kick.
    cfg(5, 3, 0, 0);
    cyc("reload5", 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cyc("us_pulse", 1, 0, 0, 0);
      cyc("us_gap", 0, 0, 0, 0);
    end
    check("in_warn", 32'(bus.state), 2);
    bus.enable = 0;
    cyc("en_drop_kick", 0, 0, 0, 1);
    check("drop.state", 32'(bus.state), 0);
    check("drop.count", 32'(bus.count), 0);
    check("drop.expired", 32'(bus.expired), 0);

    // Zero timeout expires at once; kick afterwards is ignored.
    cfg(0, 0, 0, 0);
    bus.enable = 1;
    step("load0");
    check("to0.state", 32'(bus.state), 3);
    cyc("to0_kick", 1, 0, 0, 1);
    check("to0_kick.state", 32'(bus.state), 3);
    bus.enable = 0;
    step("idle_again");

    // Asynchronous reset mid-RUN.
    cfg(6, 0, 0, 0);
    bus.enable = 1;
    step("load6");
    for (int i = 0; i < 3; i++) begin
      cyc("r_pulse", 1, 0, 0, 0);
      cyc("r_gap", 0, 0, 0, 0);
    end
    check("pre_rst.count", 32'(bus.count), 3);
    #3;
    rst_n = 0;
    #1;
    check("arst.count", 32'(bus.count), 0);
    check("arst.state", 32'(bus.state), 0);
    check("arst.expired", 32'(bus.expired), 0);
    model_reset();
    bus.enable = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step("post_rst");

`ifdef WDT_WINDOW_EN
    cfg(10, 0, 0, 4);
    bus.enable = 1;
    step("wload");
    for (int i = 0; i < 2; i++) begin
      cyc("w_pulse", 1, 0, 0, 0);
      cyc("w_gap", 0, 0, 0, 0);
    end
    cyc("w_early_kick", 0, 0, 0, 1);
    check("early.state", 32'(bus.state), 3);
    check("early.flag", 32'(bus.early_kick), 1);
    bus.enable = 0;
    step("w_idle");
    check("early.clr", 32'(bus.early_kick), 0);
    bus.enable = 1;
    step("wload2");
    for (int i = 0; i < 5; i++) begin
      cyc("w_pulse", 1, 0, 0, 0);
      cyc("w_gap", 0, 0, 0, 0);
    end
    cyc("w_ok_kick", 0, 0, 0, 1);
    check("late.count", 32'(bus.count), 10);
    check("late.state", 32'(bus.state), 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.enable     = ($urandom_range(0, 32) != 0);
      bus.usec_pulse = ($urandom_range(0, 3) == 0);
      bus.msec_pulse = ($urandom_range(0, 3) == 0);
      bus.sec_pulse  = ($urandom_range(0, 3) == 0);
      bus.kick       = ($urandom_range(0, 24) == 0);
      cfg(int'($urandom_range(1, 12)), int'($urandom_range(0, 14)),
          int'($urandom_range(0, 3)),
`ifdef WDT_WINDOW_EN
          int'($urandom_range(0, 6))
`else
          0
`endif
          );
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/watchdog_timer.md
WATCHDOG_TIMER -- requirements
Module: watchdog_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the count, timeout and threshold fields.
REQ-002 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports usec_pulse, msec_pulse, sec_pulse  input  1 each  single-cycle tick pulses from the upstream timer.
REQ-005 SHALL have port tick_sel  input  2  time base: 0=usec, 1=msec, 2=sec, 3=no tick (frozen).
REQ-006 SHALL have port enable  input  1  watchdog enable, level.
REQ-007 SHALL have port timeout  input  CNT_W  reload value, in ticks.
REQ-008 SHALL have port warn_thresh  input  CNT_W  warning level; 0 disables the warning.
REQ-009 SHALL have port kick  input  1  service request, single-cycle.
REQ-010 SHALL have port count  output  CNT_W  remaining ticks.
REQ-011 SHALL have port state  output  2  current FSM state encoding.
REQ-012 SHALL have port warn_pulse  output  1  one-cycle pulse on entry to WARN.
REQ-013 SHALL have port expired  output  1  high while in EXPIRED.

Function
REQ-014 SHALL implement states IDLE=0, RUN=1, WARN=2, EXPIRED=3.
REQ-015 IDLE with enable=1 SHALL latch timeout, warn_thresh and tick_sel, load count=timeout, and enter RUN the next cycle; if timeout=0 it SHALL enter EXPIRED instead.
REQ-016 In RUN/WARN, each selected tick SHALL decrement count by 1, with the result registered one cycle after the tick.
REQ-017 In RUN, a decrement producing count=latched warn_thresh (warn_thresh nonzero) SHALL enter WARN and assert warn_pulse for exactly that cycle.
REQ-018 In RUN or WARN, a decrement producing count=0 SHALL enter EXPIRED; if warn_thresh=0 or warn_thresh>=timeout, WARN SHALL be skipped.
REQ-019 kick in RUN/WARN SHALL re-latch the configuration, reload count=timeout, and enter RUN; kick SHALL win over a simultaneous tick.
REQ-020 kick in IDLE or EXPIRED SHALL be ignored.
REQ-021 enable=0 SHALL force IDLE the next cycle from any state, with count=0, expired=0 and warn_pulse=0; enable SHALL take precedence over kick and tick.
REQ-022 EXPIRED SHALL hold count=0 and expired=1 until enable=0.
REQ-023 Changes to timeout, warn_thresh or tick_sel between reloads SHALL have no effect until the next load.
REQ-024 Ticks whose tick_sel does not match the latched tick_sel SHALL be ignored; multiple simultaneous upstream pulses SHALL count as at most one decrement.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, count=0, warn_pulse=0, expired=0, all latched configuration=0, and early_kick=0 where present.
REQ-026 After rst_n deasserts, the first load SHALL occur on the first clock edge with enable=1.

Configuration
REQ-027 Macro WDT_WINDOW_EN defined SHALL add the input window_min (CNT_W) and the output early_kick (1).
REQ-028 With WDT_WINDOW_EN, the window_min configuration value SHALL be latched at load alongside the other configuration values.
REQ-029 With WDT_WINDOW_EN, a kick while (latched timeout - count) < latched window_min SHALL enter EXPIRED and set early_kick=1, which is cleared on entry to IDLE.
REQ-030 Without WDT_WINDOW_EN, the window_min and early_kick ports SHALL be absent, and every kick in RUN/WARN SHALL reload.

Structure
REQ-031 Package wdt_pkg SHALL hold the state enum, the tick_sel encodings and the default CNT_W.
REQ-032 A sub-module wdt_tick_sel SHALL perform the registered tick_sel selection and the OR-collapse into one tick strobe, adding one cycle of latency counted in REQ-016.

Verification
REQ-033 enable=1, timeout=5, warn_thresh=2, tick_sel=1, 5 msec_pulses -> warn_pulse after the 3rd pulse, expired=1 after the 5th pulse, count=0.
REQ-034 timeout=4 and a kick coincident with the 2nd tick -> count=4, state=RUN, no decrement on that cycle.
REQ-035 enable dropped while in WARN with a simultaneous kick -> IDLE next cycle, count=0, expired=0.
REQ-036 timeout=0 with enable=1 -> EXPIRED one cycle later; a following kick is ignored.
REQ-037 rst_n asserted mid-RUN with count=3 -> count=0 and state=IDLE with no clock edge required.
REQ-038 WDT_WINDOW_EN defined, timeout=10, window_min=4, kick at count=8 -> EXPIRED with early_kick=1; kick at count=5 -> reload to 10.
